edge_period_meter: RTL
======================

# edge_period_meter

Measures the spacing between successive single-cycle edge pulses, counted in enabled clock cycles, and delivers each measurement through a valid/ready output register. It sits directly downstream of the shift-register edge detector and consumes its one-cycle `Out` pulse on the `Edge` input. Typical uses are slow-clock frequency checks and synchronization-lock monitoring. It shares the detector's `Clock` and `Enable`, so both stages see the same slow-clock gating.

## Interface
- `CWIDTH`, default 16: width of the period counter and of `Period`. The maximum measurable period is 2^CWIDTH-1.
- `Clock`, input, 1: sole clock. All logic uses its rising edge.
- `Reset`, input, 1: asynchronous, active-low reset.
- `Enable`, input, 1: clock enable. It gates `Edge` sampling and counting. The output handshake ignores it.
- `Edge`, input, 1: one-cycle edge pulse. It is sampled only when `Enable`=1.
- `Clear`, input, 1: synchronous clear of the sticky `Overrun` flag.
- `Period`, output, CWIDTH: the last measured period, in enabled cycles.
- `Valid`, output, 1: `Period` holds an unconsumed measurement.
- `Ready`, input, 1: the consumer accepts `Period` on a cycle where `Valid`&`Ready`.
- `Timeout`, output, 1: one-cycle pulse when a measurement exceeds the counter range.
- `Overrun`, output, 1: sticky flag. Set when a result is dropped because the output register was still full.

## Operation
- **States:**
  - `IDLE`: waiting for the first edge.
  - `MEASURE`: counting since the last edge.
- **Reset** (`Reset`=0, any time, including mid-measurement):
  - state goes to `IDLE`.
  - `Count`=0.
  - `Period`=0, `Valid`=0, `Timeout`=0, `Overrun`=0.
  - Any partial measurement is discarded.
- **IDLE:**
  - Enabled `Edge` moves to `MEASURE` with `Count`=0.
  - Nothing else happens.
- **MEASURE**, on an enabled cycle:
  - If `Count`<2^CWIDTH-1 and `Edge`=1: a result of `Count`+1 is produced, `Count` returns to 0, and the state stays `MEASURE`.
  - If `Count`<2^CWIDTH-1 and `Edge`=0: `Count` increments by 1.
  - If `Count`==2^CWIDTH-1 and `Edge`=0: `Timeout` pulses, the state goes to `IDLE`, and no result is produced.
  - If `Count`==2^CWIDTH-1 and `Edge`=1: `Timeout` pulses and no result is produced. That edge restarts measurement: the state stays `MEASURE` with `Count`=0.
- **Disabled cycles:** state and `Count` hold. `Edge` is ignored.
- **Result delivery:**
  - If `Valid`=0, or `Valid`&`Ready` in the same cycle: `Period` takes the result and `Valid`=1. This is not an overrun.
  - If `Valid`=1 and `Ready`=0: the result is dropped, `Period` is unchanged, and `Overrun` is set.
- **Handshake:**
  - `Valid`&`Ready` with no new result: `Valid` goes to 0 and `Period` holds its value.
  - `Valid` never drops without `Ready`.
- **Overrun flag:**
  - `Clear` resets `Overrun` to 0.
  - When `Clear` coincides with a new overrun event, set wins.
- **Arithmetic:** `Count`+1 never wraps. The timeout rule prevents reaching 2^CWIDTH.

## Timing
- **Result latency:** `Period`/`Valid` update on the clock edge that samples the enabled `Edge`, so they are visible the following cycle.
- **Timeout latency:** `Timeout` is registered and high for exactly one cycle after the timeout cycle.
- **Period definition:** with `Enable` held at 1 and edges sampled at cycles t0 and t1, `Period`=t1-t0.
- **Back-to-back edges:** edges on consecutive enabled cycles give `Period`=1.
- **Throughput:** one result per enabled cycle is sustainable when `Ready`=1.
- **Reset release:** the outputs above hold until the first clock after `Reset` rises.

## Structure
- **Shared package** holds:
  - the state encoding (`IDLE`=1'b0, `MEASURE`=1'b1);
  - the default `CWIDTH` constant.
- **Sub-modules:** none. The counter, control logic and output register are inline.
- **Edge detector:** the parent instantiates it alongside this block. `EdgeDetect.Out` drives `Edge`; `Clock` and `Enable` are shared.

## Test plan
1. **Reset mid-measurement.** `CWIDTH`=8, `Enable`=1. Edge at cycle 10, `Reset` low at 14, released at 16, next edge at 20 → all outputs 0 from 14; no `Valid` after 20; the next edge at 25 gives `Period`=5.
2. **Basic measurement.** `Ready`=1, edges at 10 and 17 → `Valid`=1, `Period`=7 at cycle 18 for one cycle.
3. **Enable gating.** `Enable` toggles every cycle; edges sampled on enabled cycles 20 enabled cycles apart → `Period`=20. `Edge` on disabled cycles is ignored.
4. **Overrun and clear.** `Ready`=0, edges at 0, 5, 9 → `Period`=5 held; `Overrun`=1 from cycle 10. Pulse `Clear` at 12 → `Overrun`=0. `Ready` at 14 → `Valid`=0 at 15.
5. **Simultaneous consume and new result.** `Valid`=1 with `Period`=5; `Ready`=1 in the same cycle a period-4 result arrives → `Period`=4, `Valid`=1, `Overrun`=0.
6. **Timeout boundary.** `CWIDTH`=8, `Enable`=1, edge at t0.
   - Edge at t0+255 → `Period`=255.
   - No edge until t0+256 → `Timeout` pulses at t0+257 and no `Valid`. The state goes to `IDLE`.
   - Repeat with an edge exactly at t0+256 → `Timeout` pulses and measurement restarts. A further edge at t0+259 → `Period`=3.

Source files
------------

// File: rtl/edge_period_meter_pkg.sv
// Shared definitions for the edge period meter: state encoding and default counter width.
package edge_period_meter_pkg;

    localparam int CWIDTH_DEF = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/edge_period_meter.sv
// Measures spacing between single-cycle edge pulses in enabled clock cycles and
// hands each result out through a valid/ready output register.
module edge_period_meter
    import edge_period_meter_pkg::*;
#(
    parameter int CWIDTH = CWIDTH_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              Edge,
    input  logic              Clear,
    output logic [CWIDTH-1:0] Period,
    output logic              Valid,
    input  logic              Ready,
    output logic              Timeout,
    output logic              Overrun
);

    localparam logic [CWIDTH-1:0] CMAX = '1;
    localparam logic [CWIDTH-1:0] ONE  = {{(CWIDTH-1){1'b0}}, 1'b1};

    state_t            state, state_nx;
    logic [CWIDTH-1:0] count, count_nx;
    logic [CWIDTH-1:0] result;
    logic              res_vld;
    logic              tmo_nx;
    logic              ovr_evt;

    always_comb begin
        state_nx = state;
        count_nx = count;
        result   = count + ONE;
        res_vld  = 1'b0;
        tmo_nx   = 1'b0;
        if (Enable) begin
            case (state)
                IDLE: begin
                    if (Edge) begin
                        state_nx = MEASURE;
                        count_nx = '0;
                    end
                end
                MEASURE: begin
                    // A saturated counter always times out; a coincident edge restarts measurement.
                    if (count == CMAX) begin
                        tmo_nx   = 1'b1;
                        count_nx = '0;
                        state_nx = Edge ? MEASURE : IDLE;
                    end else if (Edge) begin
                        res_vld  = 1'b1;
                        count_nx = '0;
                    end else begin
                        count_nx = count + ONE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign ovr_evt = res_vld & Valid & ~Ready;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            count   <= '0;
            Timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            Timeout <= tmo_nx;
        end
    end

    // Output register: a new result is only accepted when the slot is empty or being drained.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Period  <= '0;
            Valid   <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            if (res_vld && (!Valid || Ready)) begin
                Period <= result;
                Valid  <= 1'b1;
            end else if (Valid && Ready) begin
                Valid  <= 1'b0;
            end
            if (ovr_evt) begin
                Overrun <= 1'b1;
            end else if (Clear) begin
                Overrun <= 1'b0;
            end
        end
    end

endmodule
